// File: rtl/systolic_array_nxn.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_nxn
// Purpose  : NxN output-stationary systolic matrix-multiply tile engine.
//            Computes C = A(N x K) * B(K x N) on signed Q(BIT_WIDTH-FRAC_WIDTH)
//            .FRAC_WIDTH operands. The host streams unskewed A columns and
//            B rows; skewing, pipeline flush and row-serial readout are
//            internal. acc_keep lets partial sums carry across K-blocks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (sampled only while idle)
//   k_len        in   beats to accept this run (clamped to K_MAX)
//   acc_keep     in   0 = clear accumulators at start, 1 = keep them
//   in_valid     in   beat present on west_in / north_in
//   in_ready     out  beat accepted when in_valid & in_ready
//   west_in      in   column k of A, slice i = A[i][k]
//   north_in     in   row k of B, slice j = B[k][j]
//   busy         out  run in progress
//   out_valid    out  out_row carries a result row
//   out_row_idx  out  index of the row on out_row
//   out_row      out  slice j = C[out_row_idx][j]
//   done         out  one-cycle pulse alongside the last row
// Configuration
//   SYSTOLIC_SAT_EN : when defined, results saturate to the BIT_WIDTH signed
//                     range; otherwise the low BIT_WIDTH bits are kept.
// ============================================================================
module systolic_array_nxn #(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int N          = 4,
  parameter int K_MAX      = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [$clog2(K_MAX):0] k_len,
  input  logic                   acc_keep,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*BIT_WIDTH-1:0] west_in,
  input  logic [N*BIT_WIDTH-1:0] north_in,
  output logic                   busy,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   out_row_idx,
  output logic [N*BIT_WIDTH-1:0] out_row,
  output logic                   done
);

  localparam int KW = $clog2(K_MAX) + 1;
  localparam int RW = $clog2(N);
  localparam int DW = $clog2(2 * N);

  localparam logic [KW-1:0] K_CAP      = KW'(K_MAX);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  // Last beat sits in the input register one edge after acceptance and then
  // needs 2N-2 more edges to reach PE(N-1,N-1); the row-0 readout register
  // samples one edge after that, i.e. 2N edges after the accepting edge.
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 1);

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t state;

  logic [KW-1:0] k_target;
  logic [KW-1:0] beat_cnt;
  logic [DW-1:0] drain_cnt;

  logic take;
  logic acc_clr;

  logic [BIT_WIDTH-1:0]        west_q     [N];
  logic [BIT_WIDTH-1:0]        north_q    [N];
  logic [BIT_WIDTH-1:0]        west_skew  [N];
  logic [BIT_WIDTH-1:0]        north_skew [N];
  logic [BIT_WIDTH-1:0]        a_pipe     [N][N];
  logic [BIT_WIDTH-1:0]        b_pipe     [N][N];
  logic signed [ACC_WIDTH-1:0] acc_pipe   [N][N];

  logic [RW-1:0]          row_sel;
  logic [N*BIT_WIDTH-1:0] row_data;

  // Accumulator to result: floor shift back to FRAC_WIDTH fraction bits,
  // then narrow to BIT_WIDTH.
  function automatic logic [BIT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] shifted;
    shifted = acc >>> FRAC_WIDTH;
`ifdef SYSTOLIC_SAT_EN
    if (shifted > SAT_MAX) begin
      return SAT_MAX[BIT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[BIT_WIDTH-1:0];
    end else begin
      return shifted[BIT_WIDTH-1:0];
    end
`else
    return shifted[BIT_WIDTH-1:0];
`endif
  endfunction

  assign take    = in_valid & in_ready;
  assign acc_clr = (state == S_IDLE) & start & ~acc_keep;

  // --------------------------------------------------------------------------
  // Input register: an accepted beat or a zero bubble enters every cycle, so
  // the array advances unconditionally and bubbles contribute nothing.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= '0;
        north_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        west_q[i]  <= take ? west_in[i*BIT_WIDTH +: BIT_WIDTH]  : '0;
        north_q[i] <= take ? north_in[i*BIT_WIDTH +: BIT_WIDTH] : '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Skew: lane i is delayed i cycles so that A[i][k] and B[k][j] meet in
  // PE(i,j) on the same edge after i+j hops through the array.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign west_skew[i]  = west_q[i];
      assign north_skew[i] = north_q[i];
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] w_sr [i];
      logic [BIT_WIDTH-1:0] n_sr [i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            w_sr[d] <= '0;
            n_sr[d] <= '0;
          end
        end else begin
          w_sr[0] <= west_q[i];
          n_sr[0] <= north_q[i];
          for (int d = 1; d < i; d++) begin
            w_sr[d] <= w_sr[d-1];
            n_sr[d] <= n_sr[d-1];
          end
        end
      end

      assign west_skew[i]  = w_sr[i-1];
      assign north_skew[i] = n_sr[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Processing elements: register operands for forwarding east/south and
  // accumulate the full-precision product.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [BIT_WIDTH-1:0]          a_in;
      logic [BIT_WIDTH-1:0]          b_in;
      logic [BIT_WIDTH-1:0]          a_q;
      logic [BIT_WIDTH-1:0]          b_q;
      logic signed [2*BIT_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]   acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = west_skew[i];
      end else begin : g_a_inner
        assign a_in = a_pipe[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = north_skew[j];
      end else begin : g_b_inner
        assign b_in = b_pipe[i-1][j];
      end

      assign prod = $signed(a_in) * $signed(b_in);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= a_in;
          b_q <= b_in;
          if (acc_clr) begin
            acc_q <= '0;
          end else begin
            // Sign-extended product; the sum wraps at ACC_WIDTH.
            acc_q <= acc_q + ACC_WIDTH'(prod);
          end
        end
      end

      assign a_pipe[i][j]   = a_q;
      assign b_pipe[i][j]   = b_q;
      assign acc_pipe[i][j] = acc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Readout mux: selects the row that the next clock edge will present.
  // Row 0 is loaded on the edge entering OUT; later rows on each OUT edge.
  // --------------------------------------------------------------------------
  always_comb begin
    row_sel  = (state == S_OUT) ? out_row_idx + 1'b1 : '0;
    row_data = '0;
    for (int j = 0; j < N; j++) begin
      row_data[j*BIT_WIDTH +: BIT_WIDTH] = narrow(acc_pipe[row_sel][j]);
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs. The OUT state spans exactly the
  // cycles in which out_valid is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      out_row     <= '0;
      done        <= 1'b0;
      k_target    <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (k_len == '0) begin
              // Re-emit the accumulators; a cleared array reads as zero.
              state       <= S_OUT;
              out_valid   <= 1'b1;
              out_row_idx <= '0;
              out_row     <= acc_keep ? row_data : '0;
            end else begin
              state    <= S_STREAM;
              in_ready <= 1'b1;
              k_target <= (k_len > K_CAP) ? K_CAP : k_len;
              beat_cnt <= '0;
            end
          end
        end

        S_STREAM: begin
          if (in_valid) begin
            if (beat_cnt == k_target - 1'b1) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= S_OUT;
            out_valid   <= 1'b1;
            out_row_idx <= '0;
            out_row     <= row_data;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        S_OUT: begin
          if (out_row_idx == ROW_LAST) begin
            // out_row keeps the last row after out_valid falls.
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            out_row_idx <= out_row_idx + 1'b1;
            out_row     <= row_data;
            done        <= ((out_row_idx + 1'b1) == ROW_LAST);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_nxn
// Purpose  : Directed self-checking bench for systolic_array_nxn (N=4,
//            Q8.8). Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_nxn;

  localparam int N  = 4;
  localparam int BW = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic [4:0]    k_len    = '0;
  logic          acc_keep = 1'b0;
  logic          in_valid = 1'b0;
  logic [63:0]   west_in  = '0;
  logic [63:0]   north_in = '0;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic [1:0]    out_row_idx;
  logic [63:0]   out_row;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_array_nxn #(
    .BIT_WIDTH (16),
    .FRAC_WIDTH(8),
    .N         (4),
    .K_MAX     (16),
    .ACC_WIDTH (40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .acc_keep   (acc_keep),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .west_in    (west_in),
    .north_in   (north_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_row_idx(out_row_idx),
    .out_row    (out_row),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {N{v}};
  endfunction

  // One complete run: start, stream nb beats, wait for results, read N rows.
  task automatic run(input string tag, input int kl, input int nb, input bit keep,
                     input logic [63:0] wv, input logic [63:0] nv,
                     input logic [3:0][63:0] exp, input bit bub, input bit poke);
    int  acc_n;
    int  cyc;
    int  lat;
    bit  rdy_ok;
    k_len    = kl[4:0];
    acc_keep = keep;
    west_in  = wv;
    north_in = nv;
    start    = 1'b1;
    tick;
    start = 1'b0;
    k_len = '0;
    chk({tag, ":busy_start"}, {63'd0, busy}, 64'd1);
    if (nb > 0) begin
      acc_n  = 0;
      cyc    = 0;
      rdy_ok = 1'b1;
      while (acc_n < nb && cyc < 400) begin
        in_valid = bub ? (cyc % 2 == 1) : 1'b1;
        start    = poke && (cyc == 1);
        if (in_ready !== 1'b1) rdy_ok = 1'b0;
        if (in_valid && in_ready) acc_n++;
        tick;
        cyc++;
      end
      start = 1'b0;
      chk({tag, ":in_ready_stream"}, {63'd0, rdy_ok}, 64'd1);
      // Keep offering beats: none may be taken once streaming is over.
      lat      = 0;
      in_valid = 1'b1;
      while (out_valid !== 1'b1 && lat < 40) begin
        if (in_ready) acc_n++;
        tick;
        lat++;
      end
      in_valid = 1'b0;
      chk({tag, ":beats"}, 64'(acc_n), 64'(nb));
      chk({tag, ":latency"}, 64'(lat), 64'(2 * N));
    end
    for (int r = 0; r < N; r++) begin
      chk({tag, $sformatf(":valid%0d", r)}, {63'd0, out_valid}, 64'd1);
      chk({tag, $sformatf(":idx%0d", r)}, {62'd0, out_row_idx}, 64'(r));
      chk({tag, $sformatf(":row%0d", r)}, out_row, exp[r]);
      chk({tag, $sformatf(":done%0d", r)}, {63'd0, done}, (r == N - 1) ? 64'd1 : 64'd0);
      tick;
    end
    chk({tag, ":valid_end"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ":busy_end"}, {63'd0, busy}, 64'd0);
    chk({tag, ":done_end"}, {63'd0, done}, 64'd0);
    chk({tag, ":row_hold"}, out_row, exp[N-1]);
  endtask

  initial begin
    logic [3:0][63:0] e;
    logic [15:0] exp_big;
    logic [15:0] exp_neg;

    // Reset state
    repeat (3) tick;
    chk("rst:in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst:busy", {63'd0, busy}, 64'd0);
    chk("rst:out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst:done", {63'd0, done}, 64'd0);
    chk("rst:idx", {62'd0, out_row_idx}, 64'd0);
    chk("rst:row", out_row, 64'd0);
    rst_n = 1'b1;
    tick;

    // 1.0 * 2.0 over 4 beats = 8.0
    e = {N{rep(16'h0800)}};
    run("t1", 4, 4, 1'b0, rep(16'h0100), rep(16'h0200), e, 1'b0, 1'b0);

    // Keep accumulators: 8.0 + 8.0 = 16.0
    e = {N{rep(16'h1000)}};
    run("t2", 4, 4, 1'b1, rep(16'h0100), rep(16'h0200), e, 1'b0, 1'b0);

    // Bubbles on alternate cycles leave the result unchanged
    e = {N{rep(16'h0800)}};
    run("t3", 4, 4, 1'b0, rep(16'h0100), rep(16'h0200), e, 1'b1, 1'b0);

    // 127*127*4 = 64516.0: wraps to 0x0400 or saturates to 0x7FFF
`ifdef SYSTOLIC_SAT_EN
    exp_big = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_big = 16'h0400;
    exp_neg = 16'hFC00;
`endif
    e = {N{rep(exp_big)}};
    run("t4a", 4, 4, 1'b0, rep(16'h7F00), rep(16'h7F00), e, 1'b0, 1'b0);
    // -127*127*4 = -64516.0
    e = {N{rep(exp_neg)}};
    run("t4b", 4, 4, 1'b0, rep(16'h8100), rep(16'h7F00), e, 1'b0, 1'b0);

    // Reset during DRAIN
    k_len    = 5'd4;
    acc_keep = 1'b0;
    west_in  = rep(16'h0100);
    north_in = rep(16'h0200);
    start    = 1'b1;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    repeat (4) tick;
    in_valid = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    chk("t5:busy", {63'd0, busy}, 64'd0);
    chk("t5:in_ready", {63'd0, in_ready}, 64'd0);
    chk("t5:out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5:done", {63'd0, done}, 64'd0);
    chk("t5:row", out_row, 64'd0);
    rst_n = 1'b1;
    tick;
    e = {N{rep(16'h0800)}};
    run("t5r", 4, 4, 1'b1, rep(16'h0100), rep(16'h0200), e, 1'b0, 1'b0);

    // start pulsed mid-stream is ignored; then k_len=0 re-emits
    run("t6", 4, 4, 1'b0, rep(16'h0100), rep(16'h0200), e, 1'b0, 1'b1);
    run("t6z", 0, 0, 1'b1, rep(16'h0000), rep(16'h0000), e, 1'b0, 1'b0);

    // Skew alignment: A row i = i+1, B column j = j+1, k=1 -> C = (i+1)(j+1)
    e[0] = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    e[1] = {16'h0800, 16'h0600, 16'h0400, 16'h0200};
    e[2] = {16'h0C00, 16'h0900, 16'h0600, 16'h0300};
    e[3] = {16'h1000, 16'h0C00, 16'h0800, 16'h0400};
    run("skew", 1, 1, 1'b0, {16'h0400, 16'h0300, 16'h0200, 16'h0100},
        {16'h0400, 16'h0300, 16'h0200, 16'h0100}, e, 1'b0, 1'b0);

    // k_len = 31 clamps to 16 beats: 16 * 1.0 = 16.0
    e = {N{rep(16'h1000)}};
    run("clamp", 31, 16, 1'b0, rep(16'h0100), rep(16'h0100), e, 1'b0, 1'b0);

    // Floor rounding: -0.5 * (1/256) = -1/512 -> floor to -1/256 = 0xFFFF
    e = {N{rep(16'hFFFF)}};
    run("floor", 1, 1, 1'b0, rep(16'hFF80), rep(16'h0001), e, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
